// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path:
// opcodes, FSM states and datapath mux encodings.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_ERROR  = 4'd12
  } state_e;

  localparam logic [1:0] SRCB_RT       = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_SEXT     = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

endpackage

// File: rtl/mips_perf_counter.sv
// Free-running wrap-around event counter with
// synchronous clear and count enable.
module mips_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM with shared memory port
// handshake, wait timeout, sticky fault and perf counters.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             regwrite,
  output logic             pc_en,
  output logic             alusrc_a,
  output logic [1:0]       alusrc_b,
  output logic [1:0]       aluop,
  output logic [1:0]       pc_src,
  output logic [1:0]       regdst,
  output logic [1:0]       memtoreg,
  output logic             fault,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret
);

  localparam logic [31:0] WAIT_LIM = 32'(MEM_TIMEOUT - 1);
  localparam bit          TO_EN    = (MEM_TIMEOUT != 0);

  state_e      state_q, state_d;
  logic [31:0] wait_q, wait_d;

  logic       mem_req_c, mem_we_c, iord_c;
  logic       ir_write_c, regwrite_c;
  logic       pc_write_c, branch_c;
  logic       alusrc_a_c, fault_c, retire_c;
  logic [1:0] alusrc_b_c, aluop_c, pc_src_c;
  logic [1:0] regdst_c, memtoreg_c;
  logic       mem_st;
  logic [CNT_W-1:0] cyc_cnt, ret_cnt;

  assign mem_st = (state_q == S_FETCH) ||
                  (state_q == S_MEMRD) ||
                  (state_q == S_MEMWR);

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    iord_c     = 1'b0;
    ir_write_c = 1'b0;
    regwrite_c = 1'b0;
    pc_write_c = 1'b0;
    branch_c   = 1'b0;
    alusrc_a_c = 1'b0;
    fault_c    = 1'b0;
    retire_c   = 1'b0;
    alusrc_b_c = SRCB_RT;
    aluop_c    = ALUOP_ADD;
    pc_src_c   = PCSRC_ALU;
    regdst_c   = REGDST_RT;
    memtoreg_c = MTR_ALUOUT;
    case (state_q)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        alusrc_b_c = SRCB_FOUR;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrc_b_c = SRCB_SEXT_SH2;
        case (opcode)
          OP_LW, OP_SW:           state_d = S_MEMADR;
          OP_R:                   state_d = S_EXEC;
          OP_ADDI, OP_ORI, OP_LUI: state_d = S_IEXEC;
          OP_BEQ:                 state_d = S_BRANCH;
          OP_J, OP_JAL:           state_d = S_JUMP;
          default:                state_d = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        alusrc_a_c = 1'b1;
        alusrc_b_c = SRCB_SEXT;
        state_d    = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg_c = MTR_MDR;
        retire_c   = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        iord_c    = 1'b1;
        if (mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXEC: begin
        alusrc_a_c = 1'b1;
        aluop_c    = ALUOP_FUNCT;
        state_d    = S_RWB;
      end
      S_RWB: begin
        regwrite_c = 1'b1;
        regdst_c   = REGDST_RD;
        retire_c   = 1'b1;
        state_d    = S_FETCH;
      end
      S_IEXEC: begin
        alusrc_a_c = 1'b1;
        alusrc_b_c = SRCB_SEXT;
        aluop_c    = (opcode == OP_ADDI) ? ALUOP_ADD : ALUOP_IMM;
        state_d    = S_IWB;
      end
      S_IWB: begin
        regwrite_c = 1'b1;
        retire_c   = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alusrc_a_c = 1'b1;
        aluop_c    = ALUOP_SUB;
        branch_c   = 1'b1;
        pc_src_c   = PCSRC_ALUOUT;
        retire_c   = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_write_c = 1'b1;
        pc_src_c   = PCSRC_JUMP;
        if (opcode == OP_JAL) begin
          regwrite_c = 1'b1;
          regdst_c   = REGDST_RA;
          memtoreg_c = MTR_PC;
        end
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_ERROR: fault_c = 1'b1;
      default: state_d = S_ERROR;
    endcase
    // Ready on the limit cycle still completes the access
    if (mem_st && !mem_ready) begin
      if (TO_EN && wait_q == WAIT_LIM) begin
        state_d = S_ERROR;
      end else begin
        wait_d = wait_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  mips_perf_counter #(.CNT_W(CNT_W)) u_cyc (
    .clk_i   (clock),
    .clr_i   (reset),
    .en_i    (state_q != S_ERROR),
    .count_o (cyc_cnt)
  );

  mips_perf_counter #(.CNT_W(CNT_W)) u_ret (
    .clk_i   (clock),
    .clr_i   (reset),
    .en_i    (retire_c),
    .count_o (ret_cnt)
  );

  assign mem_req     = mem_req_c & ~reset;
  assign mem_we      = mem_we_c & ~reset;
  assign iord        = iord_c & ~reset;
  assign ir_write    = ir_write_c & ~reset;
  assign regwrite    = regwrite_c & ~reset;
  assign pc_en       = (pc_write_c | (branch_c & zero)) & ~reset;
  assign alusrc_a    = alusrc_a_c & ~reset;
  assign alusrc_b    = reset ? 2'b00 : alusrc_b_c;
  assign aluop       = reset ? 2'b00 : aluop_c;
  assign pc_src      = reset ? 2'b00 : pc_src_c;
  assign regdst      = reset ? 2'b00 : regdst_c;
  assign memtoreg    = reset ? 2'b00 : memtoreg_c;
  assign fault       = fault_c & ~reset;
  assign state       = reset ? 4'd0 : state_q;
  assign cycle_count = reset ? '0 : cyc_cnt;
  assign instret     = reset ? '0 : ret_cnt;

endmodule
